alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Issue stage directly upstream of the 64-bit alu. Decodes RV64I OP (0110011) and OP-IMM (0010011)
//  instructions, reads a 32x64 register file, and presents registered A/B/shamt/func3/func7 to the alu.
//  Accepts the alu result back as writeback. A per-register scoreboard stalls issue on RAW/WAW hazards.
// PARAMETERS
//  XLEN       64  datapath width; only 64 is supported
//  BYPASS_EN  1   1: same-cycle writeback data forwarded into operand read; 0: stall until cleared
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     synchronous reset, active-high
//  in_valid   in   1     in_instr valid
//  in_ready   out  1     stage accepts in_instr this cycle
//  in_instr   in   32    RV64I instruction word
//  out_valid  out  1     A/B/shamt/func3/func7/out_rd/out_is_cmp valid to alu
//  out_ready  in   1     downstream consumes the current output this cycle
//  A          out  64    operand rs1
//  B          out  64    rs2 (OP) or sign-extended imm[11:0] (OP-IMM)
//  shamt      out  6     rs2[5:0] (OP) or instr[25:20] (OP-IMM)
//  func3      out  3     instr[14:12]
//  func7      out  7     alu function modifier, see BEHAVIOUR
//  out_rd     out  5     destination register
//  out_is_cmp out  1     1 when func3 is 010/011; writeback takes {63'b0,Comparison}, not Result
//  illegal    out  1     one-cycle pulse: unsupported instruction consumed and dropped
//  wb_en      in   1     writeback strobe
//  wb_rd      in   5     writeback register; x0 ignored
//  wb_data    in   64    writeback value
// BEHAVIOUR
//  Reset: out_valid=0, illegal=0, A/B/shamt/func3/func7/out_rd/out_is_cmp=0, busy[31:1]=0, x1..x31=0.
//  x0 reads 0 always; writes to x0 and busy[0] never take effect.
//  Handshake: transfer on in_valid&in_ready; output slot updates on that edge (latency 1 cycle).
//   in_ready = (!out_valid | out_ready) & !hazard; may depend combinationally on in_instr.
//   out_valid holds with stable outputs until out_ready=1; falls if no new transfer that cycle.
//  Decode, OP: func7 = instr[31:25]; legal iff func7==0000000, or func7==0100000 with func3 in {000,101}.
//   OP-IMM: func7=0000000 except func3=101: func7={instr[31:26],1'b0}; legal func6 000000/010000.
//   OP-IMM func3=001 requires instr[31:26]==000000. ADDI never sets func7[5] (must not become SUB).
//   Other opcodes illegal. Illegal: consumed if output slot free, illegal=1 next cycle, no output,
//   no scoreboard/regfile change. Illegal is not hazard-checked.
//  Scoreboard: issue of legal instr with rd!=0 sets busy[rd]; wb_en clears busy[wb_rd] and writes regfile.
//   Same-cycle set and clear of the same register: set wins.
//   hazard = busy[rs1] | (OP & busy[rs2]) | busy[rd], where a source/dest equal to wb_rd under wb_en
//   counts not busy when BYPASS_EN=1 (operand takes wb_data); BYPASS_EN=0: stall while busy.
//  Writeback to a non-busy register still writes the regfile.
//  Reset mid-operation: output slot and scoreboard cleared; in-flight instr discarded.
// TESTING
//  1 reset, then ADDI x1,x0,5 -> next cycle out_valid=1, A=0, B=5, func3=000, func7=0, out_rd=1; busy[1]=1.
//  2 ADD x3,x1,x2 while busy[1]=1, no wb -> in_ready=0; wb x1=5 same cycle -> issues with A=5 (BYPASS_EN=1).
//  3 SRAI x4,x1,4 (instr[31:26]=010000) -> func7=0100000, shamt=4; SUB x5,x1,x2 -> func7=0100000, func3=000.
//  4 SLTU x6,x1,x2 -> out_is_cmp=1; OP with func7=0000001 -> illegal pulse 1 cycle, out_valid stays 0.
//  5 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next instr issues.
//  6 wb_en with wb_rd=0, wb_data=FFFF..F -> later ADD x7,x0,x0 gives A=B=0; rst mid-stall -> busy cleared.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: RV64I OP/OP-IMM decode, regfile read and scoreboarded issue to the alu
module alu_operand_stage #(
  parameter int XLEN      = 64,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [5:0]      shamt,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      out_rd,
  output logic            out_is_cmp,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);
  logic [XLEN-1:0] rf [32];
  logic [31:0] busy, busy_nxt;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_op, is_opi, legal, hazard, fire, fwd1, fwd2, fwdd;
  logic [XLEN-1:0] rs1_v, rs2_v;
  assign rd  = in_instr[11:7];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  always_comb begin
    is_op  = in_instr[6:0] == 7'b0110011;
    is_opi = in_instr[6:0] == 7'b0010011;
    f7 = is_op ? in_instr[31:25] : (f3 == 3'b101 ? {in_instr[31:26], 1'b0} : 7'd0);
    legal = is_op ? (in_instr[31:25] == 7'd0 || (in_instr[31:25] == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                  : is_opi & (f3 == 3'b001 ? in_instr[31:26] == 6'd0
                            : f3 == 3'b101 ? (in_instr[31:26] == 6'd0 || in_instr[31:26] == 6'b010000) : 1'b1);
    fwd1 = BYPASS_EN && wb_en && wb_rd == rs1 && rs1 != 5'd0;
    fwd2 = BYPASS_EN && wb_en && wb_rd == rs2 && rs2 != 5'd0;
    fwdd = BYPASS_EN && wb_en && wb_rd == rd && rd != 5'd0;
    rs1_v = rs1 == 5'd0 ? '0 : fwd1 ? wb_data : rf[rs1];
    rs2_v = rs2 == 5'd0 ? '0 : fwd2 ? wb_data : rf[rs2];
    hazard = legal & ((busy[rs1] & ~fwd1) | (is_op & busy[rs2] & ~fwd2) | (busy[rd] & ~fwdd));
    in_ready = (~out_valid | out_ready) & ~hazard;
    fire = in_valid & in_ready;
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_rd] = 1'b0;
    if (fire & legal) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      A          <= '0;
      B          <= '0;
      shamt      <= '0;
      func3      <= '0;
      func7      <= '0;
      out_rd     <= '0;
      out_is_cmp <= 1'b0;
      busy       <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      illegal <= fire & ~legal;
      busy    <= busy_nxt;
      if (fire & legal) begin
        out_valid  <= 1'b1;
        A          <= rs1_v;
        B          <= is_op ? rs2_v : {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        shamt      <= is_op ? rs2_v[5:0] : in_instr[25:20];
        func3      <= f3;
        func7      <= f7;
        out_rd     <= rd;
        out_is_cmp <= f3 == 3'b010 || f3 == 3'b011;
      end else if (out_ready) out_valid <= 1'b0;
      if (wb_en && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed checks of decode, scoreboard, bypass and handshake
module tb_alu_operand_stage;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1, wb_en = 0;
  logic [31:0] in_instr = 0;
  logic [4:0] wb_rd = 0;
  logic [63:0] wb_data = 0;
  logic in_ready, out_valid, out_is_cmp, illegal;
  logic [63:0] A, B;
  logic [5:0] shamt;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [4:0] out_rd;
  int n_cmp = 0, n_err = 0;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .shamt(shamt), .func3(func3),
    .func7(func7), .out_rd(out_rd), .out_is_cmp(out_is_cmp), .illegal(illegal),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                      input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] s1,
                                      input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, 7'b0010011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", illegal); end
    n_cmp++; if ({A, B, shamt, func3, func7, out_rd, out_is_cmp} !== '0) begin n_err++; $display("FAIL reset_fields got A=%h B=%h rd=%0d want 0", A, B, out_rd); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    in_instr = i_t(12'd5, 5'd0, 3'b000, 5'd1);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b want 1", out_valid); end
    n_cmp++; if (A !== 64'd0 || B !== 64'd5) begin n_err++; $display("FAIL addi_ops got A=%h B=%h want 0/5", A, B); end
    n_cmp++; if (func3 !== 3'b000 || func7 !== 7'd0 || out_rd !== 5'd1) begin n_err++; $display("FAIL addi_fields got f3=%b f7=%b rd=%0d want 000/0/1", func3, func7, out_rd); end
  endtask

  task automatic test_bypass();
    in_instr = r_t(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
    in_valid = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall got in_ready=%b want 0", in_ready); end
    wb_en = 1; wb_rd = 5'd1; wb_data = 64'd5;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready got in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 0; wb_en = 0;
    n_cmp++; if (out_valid !== 1'b1 || A !== 64'd5 || B !== 64'd0 || out_rd !== 5'd3) begin n_err++; $display("FAIL bypass_issue got v=%b A=%h B=%h rd=%0d want 1/5/0/3", out_valid, A, B, out_rd); end
  endtask

  task automatic test_shift_sub();
    wb_en = 1; wb_rd = 5'd2; wb_data = 64'd7;
    tick();
    wb_en = 0;
    in_instr = i_t(12'h404, 5'd1, 3'b101, 5'd4);
    in_valid = 1;
    tick();
    n_cmp++; if (func7 !== 7'b0100000 || shamt !== 6'd4 || func3 !== 3'b101 || A !== 64'd5) begin n_err++; $display("FAIL srai got f7=%b sh=%0d f3=%b A=%h want 0100000/4/101/5", func7, shamt, func3, A); end
    in_instr = r_t(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5);
    tick();
    in_valid = 0;
    n_cmp++; if (func7 !== 7'b0100000 || func3 !== 3'b000 || A !== 64'd5 || B !== 64'd7 || shamt !== 6'd7) begin n_err++; $display("FAIL sub got f7=%b f3=%b A=%h B=%h sh=%0d want 0100000/000/5/7/7", func7, func3, A, B, shamt); end
    in_instr = i_t(12'hFFF, 5'd1, 3'b000, 5'd13);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (func7 !== 7'd0 || B !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL addi_neg got f7=%b B=%h want 0/all-ones", func7, B); end
  endtask

  task automatic test_cmp_illegal();
    in_instr = r_t(7'd0, 5'd2, 5'd1, 3'b011, 5'd6);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (out_is_cmp !== 1'b1 || A !== 64'd5 || B !== 64'd7) begin n_err++; $display("FAIL sltu got cmp=%b A=%h B=%h want 1/5/7", out_is_cmp, A, B); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain got out_valid=%b want 0", out_valid); end
    in_instr = r_t(7'b0000001, 5'd3, 5'd3, 3'b000, 5'd3);
    in_valid = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_no_hazard got in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL illegal_pulse got ill=%b v=%b want 1/0", illegal, out_valid); end
    tick();
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL illegal_width got ill=%b want 0", illegal); end
    in_instr = i_t({6'b000001, 6'd1}, 5'd1, 3'b001, 5'd8);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL slli_bad got ill=%b v=%b want 1/0", illegal, out_valid); end
    in_instr = i_t(12'd1, 5'd0, 3'b000, 5'd8);
    in_valid = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_no_busy got in_ready=%b want 1", in_ready); end
    in_valid = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    in_instr = i_t(12'd1, 5'd0, 3'b000, 5'd9);
    in_valid = 1;
    tick();
    out_ready = 0;
    in_instr = i_t(12'd2, 5'd0, 3'b000, 5'd10);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || B !== 64'd1 || out_rd !== 5'd9 || in_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d got v=%b B=%h rd=%0d rdy=%b want 1/1/9/0", i, out_valid, B, out_rd, in_ready); end
      tick();
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || B !== 64'd2 || out_rd !== 5'd10) begin n_err++; $display("FAIL release_issue got v=%b B=%h rd=%0d want 1/2/10", out_valid, B, out_rd); end
    tick();
  endtask

  task automatic test_x0_reset();
    wb_en = 1; wb_rd = 5'd0; wb_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    wb_en = 0;
    in_instr = r_t(7'd0, 5'd0, 5'd0, 3'b000, 5'd7);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (A !== 64'd0 || B !== 64'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL x0_read got A=%h B=%h v=%b want 0/0/1", A, B, out_valid); end
    in_instr = i_t(12'd1, 5'd0, 3'b000, 5'd3);
    in_valid = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall got in_ready=%b want 0", in_ready); end
    in_instr = r_t(7'd0, 5'd5, 5'd1, 3'b000, 5'd11);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rs2_stall got in_ready=%b want 0", in_ready); end
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    in_instr = r_t(7'd0, 5'd5, 5'd3, 3'b000, 5'd4);
    in_valid = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_clear got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    tick();
    in_valid = 0;
    n_cmp++; if (A !== 64'd0 || out_rd !== 5'd4) begin n_err++; $display("FAIL rst_regfile got A=%h rd=%0d want 0/4", A, out_rd); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_shift_sub();
    test_cmp_illegal();
    test_back_to_back();
    test_x0_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
